// File: rtl/accel_bus_regs.sv
// Register-file slave for the CPU accelerator bus: decodes 8 registers,
// launches the accelerator core and tracks busy/done/error and cycle count.
//
// state  | meaning
// IDLE   | waiting for bus_en & bus_start
// ACCESS | one cycle: read data registered, write committed on exit
// DONE   | bus_done high, hold until bus_start drops
module accel_bus_regs #(
    parameter int                DATA_W = 16,
    parameter logic [DATA_W-1:0] ACC_ID = 16'hA5C1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_en,
    input  logic              bus_start,
    input  logic [1:0]        bus_rdwr,
    input  logic [2:0]        bus_regaddr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rdata_oe,
    output logic              bus_done,
    output logic              acc_start,
    input  logic              acc_busy,
    input  logic              acc_done,
    input  logic [DATA_W-1:0] acc_result,
    output logic [DATA_W-1:0] acc_src,
    output logic [DATA_W-1:0] acc_dst,
    output logic [DATA_W-1:0] acc_len,
    output logic              irq
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_SRC    = 3'd2;
    localparam logic [2:0] A_DST    = 3'd3;
    localparam logic [2:0] A_LEN    = 3'd4;
    localparam logic [2:0] A_RESULT = 3'd5;
    localparam logic [2:0] A_CYCLE  = 3'd6;
    localparam logic [2:0] A_ID     = 3'd7;

    state_t            state, next_state;
    logic [2:0]        addr_q;
    logic [1:0]        rdwr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] src_q, dst_q, len_q, result_q, cycle_q;
    logic              irq_en_q, done_q, err_q;
    logic [DATA_W-1:0] rd_mux;
    logic              rd_req, wr_req, commit;
    logic              go_req, go_ok, go_bad, w1c_done, w1c_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus_en && bus_start) next_state = ACCESS;
            ACCESS:  next_state = bus_en ? DONE : IDLE;
            DONE:    if (!bus_en || !bus_start) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign rd_req   = (rdwr_q == 2'b10);
    assign wr_req   = (rdwr_q == 2'b01);
    assign commit   = (state == ACCESS) && bus_en && wr_req;
    assign go_req   = commit && (addr_q == A_CTRL) && wdata_q[0];
    assign go_ok    = go_req && !acc_busy && (len_q != '0);
    assign go_bad   = go_req && !go_ok;
    assign w1c_done = commit && (addr_q == A_STATUS) && wdata_q[1];
    assign w1c_err  = commit && (addr_q == A_STATUS) && wdata_q[2];

    assign bus_done     = (state == DONE);
    assign bus_rdata_oe = (state == DONE) && rd_req;
    assign irq          = done_q & irq_en_q;
    assign acc_src      = src_q;
    assign acc_dst      = dst_q;
    assign acc_len      = len_q;

    always_comb begin
        rd_mux = '0;
        case (addr_q)
            A_CTRL:   rd_mux = {{(DATA_W-2){1'b0}}, irq_en_q, 1'b0};
            A_STATUS: rd_mux = {{(DATA_W-3){1'b0}}, err_q, done_q, acc_busy};
            A_SRC:    rd_mux = src_q;
            A_DST:    rd_mux = dst_q;
            A_LEN:    rd_mux = len_q;
            A_RESULT: rd_mux = result_q;
            A_CYCLE:  rd_mux = cycle_q;
            A_ID:     rd_mux = ACC_ID;
            default:  rd_mux = '0;
        endcase
    end

    // Request fields are captured at the sampling edge so the CPU may change them during ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            rdwr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && bus_en && bus_start) begin
            addr_q  <= bus_regaddr;
            rdwr_q  <= bus_rdwr;
            wdata_q <= bus_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  bus_rdata <= '0;
        else if (state == ACCESS) bus_rdata <= (rd_req && bus_en) ? rd_mux : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            irq_en_q <= 1'b0;
        end else if (commit) begin
            case (addr_q)
                A_CTRL:  irq_en_q <= wdata_q[1];
                A_SRC:   src_q    <= wdata_q;
                A_DST:   dst_q    <= wdata_q;
                A_LEN:   len_q    <= wdata_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_start <= 1'b0;
            cycle_q   <= '0;
        end else begin
            acc_start <= go_ok;
            if (go_ok)                          cycle_q <= '0;
            else if (acc_busy && cycle_q != '1) cycle_q <= cycle_q + 1'b1;
        end
    end

    // Hardware set wins over a same-cycle write-1-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (acc_done) result_q <= acc_result;
            if (acc_done)      done_q <= 1'b1;
            else if (w1c_done) done_q <= 1'b0;
            if (go_bad)       err_q <= 1'b1;
            else if (w1c_err) err_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accel_bus_regs.sv
// Directed bench for accel_bus_regs: bus handshake, register map, launch,
// status tracking and asynchronous reset during a transaction.
module tb_accel_bus_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_en, bus_start;
    logic [1:0]  bus_rdwr;
    logic [2:0]  bus_regaddr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_rdata_oe, bus_done, acc_start;
    logic        acc_busy, acc_done;
    logic [15:0] acc_result;
    logic [15:0] acc_src, acc_dst, acc_len;
    logic        irq;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    accel_bus_regs #(.DATA_W(16), .ACC_ID(16'hA5C1)) dut (
        .clk(clk), .rst(rst),
        .bus_en(bus_en), .bus_start(bus_start), .bus_rdwr(bus_rdwr),
        .bus_regaddr(bus_regaddr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_rdata_oe(bus_rdata_oe), .bus_done(bus_done),
        .acc_start(acc_start), .acc_busy(acc_busy), .acc_done(acc_done),
        .acc_result(acc_result), .acc_src(acc_src), .acc_dst(acc_dst),
        .acc_len(acc_len), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (acc_start === 1'b1) start_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [1:0] rw, input logic [2:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output logic oe, output int lat);
        bus_en = 1'b1; bus_start = 1'b1;
        bus_rdwr = rw; bus_regaddr = a; bus_wdata = wd;
        lat = 0;
        while (bus_done !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        rd = bus_rdata;
        oe = bus_rdata_oe;
        bus_start = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        logic [15:0] rd; logic oe; int lat;
        xfer(2'b01, a, d, rd, oe, lat);
        check("wr_latency", lat, 2);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] rd; logic oe; int lat;
        xfer(2'b10, a, 16'h0000, rd, oe, lat);
        check(tag, rd, exp);
        check({tag, "_oe"}, oe, 1'b1);
    endtask

    initial begin
        logic [15:0] rd;
        logic        oe;
        int          lat;

        rst = 1'b1; bus_en = 1'b0; bus_start = 1'b0; bus_rdwr = 2'b00;
        bus_regaddr = 3'd0; bus_wdata = 16'h0000;
        acc_busy = 1'b0; acc_done = 1'b0; acc_result = 16'h0000;
        tick(); tick();
        check("rst_done", bus_done, 1'b0);
        check("rst_oe", bus_rdata_oe, 1'b0);
        check("rst_rdata", bus_rdata, 16'h0000);
        check("rst_start", acc_start, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_cfg", {acc_src, acc_dst, acc_len}, 48'h0);
        rst = 1'b0;
        tick();

        // 1: ID read with latency and 4-phase release
        bus_en = 1'b1; bus_start = 1'b1; bus_rdwr = 2'b10; bus_regaddr = 3'd7;
        tick();
        check("id_done_early", bus_done, 1'b0);
        tick();
        check("id_done", bus_done, 1'b1);
        check("id_rdata", bus_rdata, 16'hA5C1);
        check("id_oe", bus_rdata_oe, 1'b1);
        tick();
        check("id_hold", bus_done, 1'b1);
        bus_start = 1'b0;
        tick();
        check("id_release", bus_done, 1'b0);
        check("id_oe_release", bus_rdata_oe, 1'b0);

        // 2: RW config registers, RO writes ignored, invalid rdwr
        wr(3'd2, 16'h0100);
        wr(3'd4, 16'h0010);
        wr(3'd3, 16'hCAFE);
        rd_chk("src_rb", 3'd2, 16'h0100);
        rd_chk("len_rb", 3'd4, 16'h0010);
        rd_chk("dst_rb", 3'd3, 16'hCAFE);
        check("acc_cfg", {acc_src, acc_dst, acc_len}, {16'h0100, 16'hCAFE, 16'h0010});
        wr(3'd5, 16'hFFFF);
        wr(3'd7, 16'h0000);
        rd_chk("result_ro", 3'd5, 16'h0000);
        rd_chk("id_ro", 3'd7, 16'hA5C1);
        xfer(2'b11, 3'd7, 16'h0000, rd, oe, lat);
        check("inv_latency", lat, 2);
        check("inv_rdata", rd, 16'h0000);
        check("inv_oe", oe, 1'b0);
        xfer(2'b00, 3'd2, 16'h5A5A, rd, oe, lat);
        rd_chk("inv_no_write", 3'd2, 16'h0100);

        // 3: launch, busy for 20 cycles, completion
        wr(3'd4, 16'h0008);
        wr(3'd0, 16'h0003);
        check("launch_pulses", start_cnt, 1);
        check("launch_pulse_end", acc_start, 1'b0);
        rd_chk("ctrl_rb", 3'd0, 16'h0002);
        acc_busy = 1'b1;
        repeat (20) tick();
        acc_busy = 1'b0; acc_done = 1'b1; acc_result = 16'h1234;
        tick();
        acc_done = 1'b0;
        rd_chk("status_done", 3'd1, 16'h0002);
        rd_chk("result", 3'd5, 16'h1234);
        rd_chk("cycle", 3'd6, 16'd20);
        check("irq_set", irq, 1'b1);
        wr(3'd1, 16'h0002);
        check("irq_clr", irq, 1'b0);
        rd_chk("status_clr", 3'd1, 16'h0000);

        // 4: go while busy, go with LEN==0
        acc_busy = 1'b1;
        wr(3'd0, 16'h0001);
        rd_chk("status_err_busy", 3'd1, 16'h0005);
        wr(3'd1, 16'h0004);
        acc_busy = 1'b0;
        rd_chk("status_err_clr", 3'd1, 16'h0000);
        wr(3'd4, 16'h0000);
        wr(3'd0, 16'h0001);
        rd_chk("status_err_len", 3'd1, 16'h0004);
        check("no_extra_launch", start_cnt, 1);
        wr(3'd1, 16'h0004);
        rd_chk("status_err_clr2", 3'd1, 16'h0000);

        // 5: acc_done coincident with W1C of done; bus_en drop in ACCESS
        bus_en = 1'b1; bus_start = 1'b1; bus_rdwr = 2'b01; bus_regaddr = 3'd1;
        bus_wdata = 16'h0002;
        tick();
        acc_done = 1'b1; acc_result = 16'h7777;
        tick();
        acc_done = 1'b0;
        check("w1c_race_done", bus_done, 1'b1);
        bus_start = 1'b0;
        tick();
        rd_chk("w1c_race_status", 3'd1, 16'h0002);
        rd_chk("w1c_race_result", 3'd5, 16'h7777);
        bus_en = 1'b1; bus_start = 1'b1; bus_rdwr = 2'b01; bus_regaddr = 3'd2;
        bus_wdata = 16'hBEEF;
        tick();
        bus_en = 1'b0;
        tick();
        check("abort_done", bus_done, 1'b0);
        bus_start = 1'b0;
        tick();
        rd_chk("abort_no_write", 3'd2, 16'h0100);

        // 6: reset during DONE of a read
        wr(3'd0, 16'h0002);
        check("pre_rst_irq", irq, 1'b1);
        bus_en = 1'b1; bus_start = 1'b1; bus_rdwr = 2'b10; bus_regaddr = 3'd2;
        tick(); tick();
        check("pre_rst_done", bus_done, 1'b1);
        check("pre_rst_rdata", bus_rdata, 16'h0100);
        rst = 1'b1;
        #1;
        check("mid_rst_done", bus_done, 1'b0);
        check("mid_rst_oe", bus_rdata_oe, 1'b0);
        check("mid_rst_rdata", bus_rdata, 16'h0000);
        check("mid_rst_irq", irq, 1'b0);
        bus_start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_cfg", {acc_src, acc_dst, acc_len}, 48'h0);
        rd_chk("post_rst_ctrl", 3'd0, 16'h0000);
        rd_chk("post_rst_status", 3'd1, 16'h0000);
        rd_chk("post_rst_result", 3'd5, 16'h0000);
        rd_chk("post_rst_cycle", 3'd6, 16'h0000);
        check("post_rst_launches", start_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
